// File: rtl/serial_addsub_pkg.sv
// Shared state encoding and elaboration helpers for serial_addsub.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_addsub_full_adder_cell.sv
// One-bit full adder; serial_addsub chains DIGIT of these per cycle.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit with start/busy/done handshake.
// Define SERIAL_ADDSUB_ZERO_FLAG_EN to add the registered zero output.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (clog2(N) == 0) ? 1 : clog2(N);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s_dig;

    assign c[0] = carry;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (opa[i]),
            .b    (opb[i]),
            .cin  (c[i]),
            .s    (s_dig[i]),
            .cout (c[i+1])
        );
    end

    // New digit enters at the top; after N steps the LSB digit has reached bit 0.
    always_comb begin
        acc_next = WIDTH'({s_dig, acc} >> DIGIT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            zero  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    acc   <= acc_next;
                    carry <= c[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        sum   <= acc_next;
                        cout  <= c[DIGIT];
                        ovf   <= c[DIGIT] ^ c[DIGIT-1];
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
                        zero  <= (acc_next == '0);
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: three instances (8/1, 8/4, 16/4).
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [7:0]  sum0;
    logic [7:0]  sum1;
    logic [15:0] sum2;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic [2:0]  zero;
`endif

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d0 (
        .clk(clk), .resetn(resetn), .start(start[0]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .busy(busy[0]), .done(done[0]), .sum(sum0), .cout(cout[0]), .ovf(ovf[0])
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        , .zero(zero[0])
`endif
    );

    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d1 (
        .clk(clk), .resetn(resetn), .start(start[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .busy(busy[1]), .done(done[1]), .sum(sum1), .cout(cout[1]), .ovf(ovf[1])
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        , .zero(zero[1])
`endif
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d2 (
        .clk(clk), .resetn(resetn), .start(start[2]), .sub(sub), .a(a), .b(b),
        .busy(busy[2]), .done(done[2]), .sum(sum2), .cout(cout[2]), .ovf(ovf[2])
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        , .zero(zero[2])
`endif
    );

    function automatic int lat(input int w);
        return (w == 0) ? 8 : (w == 1) ? 2 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic pop_cmp(input int w, input logic [15:0] s);
        exp_t e;
        int   n;
        n = (w == 0) ? q0.size() : (w == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_done got=done exp=no_done (cyc %0d)", w, cyc);
        end else begin
            if (w == 0) e = q0.pop_front();
            else if (w == 1) e = q1.pop_front();
            else e = q2.pop_front();
            chk($sformatf("dut%0d_sum", w), 32'(s), 32'(e.sum));
            chk($sformatf("dut%0d_cout", w), 32'(cout[w]), 32'(e.cout));
            chk($sformatf("dut%0d_ovf", w), 32'(ovf[w]), 32'(e.ovf));
            chk($sformatf("dut%0d_latency_cyc", w), cyc, e.cyc);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            chk($sformatf("dut%0d_zero", w), 32'(zero[w]), 32'(e.sum == 16'h0));
`endif
        end
    endtask

    always @(negedge clk) begin
        if (done[0]) pop_cmp(0, {8'h00, sum0});
        if (done[1]) pop_cmp(1, {8'h00, sum1});
        if (done[2]) pop_cmp(2, sum2);
    end

    // Called just after a negedge; start is sampled on the following posedge.
    task automatic issue(input int w, input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        e.cyc  = cyc + 1 + lat(w);
        if (w == 0) q0.push_back(e);
        else if (w == 1) q1.push_back(e);
        else q2.push_back(e);
        sub      = s;
        a        = x;
        b        = y;
        start[w] = 1'b1;
        @(negedge clk);
        start[w] = 1'b0;
    endtask

    task automatic wait_ready(input int w);
        int n;
        n = 0;
        while (busy[w] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk($sformatf("dut%0d_ready_timeout", w), 32'(busy[w]), 0);
    endtask

    initial begin
        logic [15:0] x, y, yy;
        logic [16:0] r;
        logic        s, eo;
        int          n;

        sub = 1'b0; a = '0; b = '0; start = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum0", 32'(sum0), 0);
        chk("rst_sum2", 32'(sum2), 0);
        chk("rst_cout_ovf", 32'({cout, ovf}), 0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: 0x7F + 0x01, busy held for exactly 8 cycles
        issue(0, 1'b0, 16'h007F, 16'h0001, 16'h0080, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_busy_%0d", i), 32'(busy[0]), 1);
            @(negedge clk);
        end
        chk("t1_busy_end", 32'(busy[0]), 0);
        chk("t1_done_pulse", 32'(done[0]), 1);

        // 2: subtractions
        wait_ready(0);
        issue(0, 1'b1, 16'h0000, 16'h0001, 16'h00FF, 1'b0, 1'b0);
        wait_ready(0);
        issue(0, 1'b1, 16'h0080, 16'h0001, 16'h007F, 1'b1, 1'b1);

        // 3: DIGIT=4 wrap to zero
        issue(1, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        wait_ready(1);
        issue(1, 1'b1, 16'h0005, 16'h0007, 16'h00FE, 1'b0, 1'b0);

        // 4: start while busy is ignored; start in DONE cycle is accepted
        wait_ready(0);
        issue(0, 1'b0, 16'h0012, 16'h0034, 16'h0046, 1'b0, 1'b0);
        sub = 1'b1; a = 16'h0055; b = 16'h00AA; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (!done[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_done_seen", 32'(done[0]), 1);
        issue(0, 1'b0, 16'h0040, 16'h0040, 16'h0080, 1'b0, 1'b1);
        chk("t4_b2b_busy", 32'(busy[0]), 1);

        // 5: async reset three cycles into RUN
        wait_ready(0);
        sub = 1'b0; a = 16'h0011; b = 16'h0022; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("t5_busy", 32'(busy[0]), 0);
        chk("t5_done", 32'(done[0]), 0);
        chk("t5_sum", 32'(sum0), 0);
        chk("t5_cout_ovf", 32'({cout[0], ovf[0]}), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (12) @(negedge clk);
        issue(0, 1'b0, 16'h0011, 16'h0022, 16'h0033, 1'b0, 1'b0);

        // 6: WIDTH=16 DIGIT=4, directed then reference-model sweep
        wait_ready(2);
        issue(2, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        wait_ready(2);
        issue(2, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            wait_ready(2);
            x  = 16'($urandom);
            y  = 16'($urandom);
            s  = 1'($urandom_range(0, 1));
            yy = s ? ~y : y;
            r  = {1'b0, x} + {1'b0, yy} + {16'h0, s};
            eo = s ? ((x[15] != y[15]) && (r[15] != x[15]))
                   : ((x[15] == y[15]) && (r[15] != x[15]));
            issue(2, s, x, y, r[15:0], r[16], eo);
        end

        wait_ready(0);
        wait_ready(1);
        wait_ready(2);
        repeat (4) @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
